lfsr_seq_ctrl: RTL and testbench

- Sequencer that owns an 8-bit Fibonacci LFSR and turns it into a bounded pseudo-random sample stream.
- A requester configures a seed and a beat count, pulses start, and receives exactly that many samples over a valid/ready interface, then a done pulse.
- Sits between the test/pattern-generation logic and any consumer of PRBS bytes.
- Owns seed loading, stepping only on accepted beats, abort, and configuration protection.

---
 rtl/lfsr_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// Bounded PRBS sequencer: loads a seed, emits cfg_count LFSR bytes over valid/ready, pulses done.
// Build option LFSR_LOCKUP_GUARD_EN swaps an all-zero seed for DEFAULT_SEED and flags err_seed.
module lfsr_seq_ctrl #(
    parameter int unsigned CNT_W        = 8,
    parameter logic [7:0]  DEFAULT_SEED = 8'hBD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_seed,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             err_cfg
`ifdef LFSR_LOCKUP_GUARD_EN
    ,
    output logic             err_seed
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       r_state;
    logic [7:0]       r_seed;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_lfsr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_err_cfg;

    logic [1:0]       w_state_nx;
    logic [7:0]       w_seed_nx;
    logic [CNT_W-1:0] w_count_nx;
    logic [7:0]       w_lfsr_nx;
    logic [CNT_W-1:0] w_remaining_nx;
    logic             w_err_cfg_nx;
    logic             w_handshake;
    logic             w_last;
    logic [7:0]       w_load_seed;

`ifdef LFSR_LOCKUP_GUARD_EN
    logic r_err_seed;
    logic w_err_seed_nx;

    assign w_load_seed = (r_seed == 8'h00) ? DEFAULT_SEED : r_seed;
    assign err_seed    = r_err_seed;
`else
    assign w_load_seed = r_seed;
`endif

    assign w_handshake = out_valid && out_ready;
    assign w_last      = (r_remaining == CNT_W'(1));

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign out_valid = (r_state == RUN);
    assign out_last  = (r_state == RUN) && w_last;
    assign out_data  = r_lfsr;
    assign err_cfg   = r_err_cfg;

    always_comb begin
        w_state_nx     = r_state;
        w_seed_nx      = r_seed;
        w_count_nx     = r_count;
        w_lfsr_nx      = r_lfsr;
        w_remaining_nx = r_remaining;
        w_err_cfg_nx   = r_err_cfg || (cfg_we && (r_state != IDLE));
`ifdef LFSR_LOCKUP_GUARD_EN
        w_err_seed_nx  = r_err_seed;
`endif
        case (r_state)
            IDLE: begin
                if (cfg_we) begin
                    w_seed_nx  = cfg_seed;
                    w_count_nx = cfg_count;
                end
                if (start) begin
                    w_state_nx = LOAD;
                end
            end
            LOAD: begin
                w_lfsr_nx      = w_load_seed;
                w_remaining_nx = r_count;
`ifdef LFSR_LOCKUP_GUARD_EN
                if (r_seed == 8'h00) begin
                    w_err_seed_nx = 1'b1;
                end
`endif
                if (abort || (r_count == '0)) begin
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                // abort takes priority: a same-cycle handshake neither steps nor counts
                if (abort) begin
                    w_state_nx = DONE;
                end else if (w_handshake) begin
                    w_lfsr_nx      = {r_lfsr[6:0], r_lfsr[1] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[7]};
                    w_remaining_nx = r_remaining - CNT_W'(1);
                    if (w_last) begin
                        w_state_nx = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_seed      <= DEFAULT_SEED;
            r_count     <= '0;
            r_lfsr      <= 8'h00;
            r_remaining <= '0;
            r_err_cfg   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_seed      <= w_seed_nx;
            r_count     <= w_count_nx;
            r_lfsr      <= w_lfsr_nx;
            r_remaining <= w_remaining_nx;
            r_err_cfg   <= w_err_cfg_nx;
        end
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_seed <= 1'b0;
        end else begin
            r_err_seed <= w_err_seed_nx;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: expected beats are queued at start, checked on handshakes.
// Covers the LFSR_LOCKUP_GUARD_EN build when that macro is defined.
module tb_lfsr_seq_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [7:0]       cfg_seed;
    logic [CNT_W-1:0] cfg_count;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             out_ready;
    logic             err_cfg;
`ifdef LFSR_LOCKUP_GUARD_EN
    logic             err_seed;
`endif

    lfsr_seq_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_SEED (8'hBD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_seed  (cfg_seed),
        .cfg_count (cfg_count),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_cfg   (err_cfg)
`ifdef LFSR_LOCKUP_GUARD_EN
        ,
        .err_seed  (err_seed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    done_cnt, busy_cnt, valid_cnt;
    int    done_cyc, start_cyc, last_cyc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[1] ^ v[2] ^ v[3] ^ v[7]};
    endfunction

    // Queue n_beats of the stream from seed; last flag on beat index count-1
    task automatic push_seq(input logic [7:0] seed, input int n_beats, input int count);
        logic [7:0] v;
        v = seed;
        for (int i = 0; i < n_beats; i++) begin
            sb_q.push_back({v, (i == count - 1)});
            v = lfsr_step(v);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        beat_t exp_b;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (out_valid) valid_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (start && !busy) start_cyc = cyc;
            if (out_valid && out_ready && !abort) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", sb_q.size(), 1);
                end else begin
                    exp_b = sb_q.pop_front();
                    check_eq("beat_data", {24'h0, out_data}, {24'h0, exp_b.data});
                    check_eq("beat_last", {31'h0, out_last}, {31'h0, exp_b.last});
                    if (out_last) last_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        done_cnt  = 0;
        busy_cnt  = 0;
        valid_cnt = 0;
        done_cyc  = -100;
        start_cyc = -200;
        last_cyc  = -300;
    endtask

    task automatic configure(input logic [7:0] seed, input logic [CNT_W-1:0] count);
        cfg_we    = 1'b1;
        cfg_seed  = seed;
        cfg_count = count;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check_eq(tag, {31'h0, out_valid}, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_idle"}, {31'h0, busy}, 0);
        check_eq({tag, "_sb_drained"}, sb_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_seed  = 8'h00;
        cfg_count = '0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        clr_stats();
        tick();
        tick();
        check_eq("rst_busy", {31'h0, busy}, 0);
        check_eq("rst_done", {31'h0, done}, 0);
        check_eq("rst_valid", {31'h0, out_valid}, 0);
        check_eq("rst_data", {24'h0, out_data}, 0);
        check_eq("rst_last", {31'h0, out_last}, 0);
        check_eq("rst_err_cfg", {31'h0, err_cfg}, 0);
`ifdef LFSR_LOCKUP_GUARD_EN
        check_eq("rst_err_seed", {31'h0, err_seed}, 0);
`endif
        rst = 1'b0;
        tick();

        // Default config has count 0: no beats, a single done two cycles after start
        clr_stats();
        pulse_start();
        wait_idle("cnt0");
        check_eq("cnt0_done_cnt", done_cnt, 1);
        check_eq("cnt0_busy_cycles", busy_cnt, 2);
        check_eq("cnt0_valid_cycles", valid_cnt, 0);
        check_eq("cnt0_done_latency", done_cyc - start_cyc, 2);

        // Three beats with the consumer always ready
        clr_stats();
        out_ready = 1'b1;
        configure(8'hBD, 8'd3);
        sb_q.push_back({8'hBD, 1'b0});
        sb_q.push_back({8'h7B, 1'b0});
        sb_q.push_back({8'hF6, 1'b1});
        pulse_start();
        wait_idle("run3");
        check_eq("run3_done_cnt", done_cnt, 1);
        check_eq("run3_done_after_last", done_cyc - last_cyc, 1);
        check_eq("run3_valid_cycles", valid_cnt, 3);

        // Back-pressure on beat 2 for four cycles
        clr_stats();
        out_ready = 1'b0;
        push_seq(8'hBD, 3, 3);
        pulse_start();
        wait_valid("bp_valid");
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bp_hold_data", {24'h0, out_data}, 32'h7B);
            check_eq("bp_hold_last", {31'h0, out_last}, 0);
            check_eq("bp_hold_valid", {31'h0, out_valid}, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle("bp");
        check_eq("bp_done_cnt", done_cnt, 1);

        // Abort coincident with the handshake of beat 3
        clr_stats();
        configure(8'hBD, 8'd10);
        push_seq(8'hBD, 2, 10);
        pulse_start();
        wait_valid("ab_valid");
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_eq("ab_valid_drop", {31'h0, out_valid}, 0);
        check_eq("ab_done", {31'h0, done}, 1);
        check_eq("ab_no_step", {24'h0, out_data}, 32'hF6);
        wait_idle("ab");
        check_eq("ab_done_cnt", done_cnt, 1);
        configure(8'hBD, 8'd1);
        sb_q.push_back({8'hBD, 1'b1});
        pulse_start();
        wait_idle("ab_next");

        // Config write while running is dropped and flagged
        clr_stats();
        out_ready = 1'b0;
        configure(8'hBD, 8'd3);
        push_seq(8'hBD, 3, 3);
        pulse_start();
        wait_valid("cw_valid");
        tick();
        cfg_we    = 1'b1;
        cfg_seed  = 8'h55;
        cfg_count = 8'd7;
        tick();
        cfg_we    = 1'b0;
        @(negedge clk);
        check_eq("cw_err_cfg", {31'h0, err_cfg}, 1);
        check_eq("cw_data_kept", {24'h0, out_data}, 32'hBD);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle("cw");
        push_seq(8'hBD, 3, 3);
        pulse_start();
        wait_idle("cw_next");
        check_eq("cw_err_sticky", {31'h0, err_cfg}, 1);

        // Zero seed
        configure(8'h00, 8'd2);
`ifdef LFSR_LOCKUP_GUARD_EN
        push_seq(8'hBD, 2, 2);
`else
        push_seq(8'h00, 2, 2);
`endif
        pulse_start();
        wait_idle("zseed");
`ifdef LFSR_LOCKUP_GUARD_EN
        check_eq("zseed_err_seed", {31'h0, err_seed}, 1);
`endif

        // Reset mid-sequence: immediate return to reset values, no done pulse
        clr_stats();
        configure(8'hBD, 8'd10);
        push_seq(8'hBD, 10, 10);
        pulse_start();
        wait_valid("mr_valid");
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("mr_busy", {31'h0, busy}, 0);
        check_eq("mr_valid", {31'h0, out_valid}, 0);
        check_eq("mr_data", {24'h0, out_data}, 0);
        check_eq("mr_err_cfg", {31'h0, err_cfg}, 0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_eq("mr_no_done", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
